// File: rtl/ram4k16_busctl_pkg.sv
// ram4k16_busctl_pkg
//   Shared definitions for the 68000 work-RAM bus controller: FSM state
//   encodings, RAM geometry and the inactive level of the active-low strobes.
package ram4k16_busctl_pkg;

   localparam int   RAM_AW     = 12;
   localparam int   RAM_DW     = 16;
   localparam logic STROBE_OFF = 1'b1;

   typedef enum logic [2:0] {
      ST_INIT    = 3'd0,
      ST_IDLE    = 3'd1,
      ST_SETUP   = 3'd2,
      ST_STROBE  = 3'd3,
      ST_ACK     = 3'd4,
      ST_RELEASE = 3'd5
   } state_t;

endpackage

// File: rtl/ram4k16_busctl_init_clr.sv
// ram4k16_init_clr
//   Zero-fill address generator. After reset (when CLEAR_ON_RESET is set) or
//   on i_start it walks the word address from 0 to the last RAM word, one
//   word per clock, then drops o_busy.
// Ports:
//   i_clk    clock (rising edge)
//   i_rst    asynchronous active-high reset; restarts the fill from word 0
//   i_start  restart the fill from word 0
//   o_busy   high while the fill runs
//   o_done   high during the clock that presents the last word
//   o_addr   word address currently being cleared
module ram4k16_init_clr
   import ram4k16_busctl_pkg::*;
#(
   parameter logic CLEAR_ON_RESET = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   output logic              o_busy,
   output logic              o_done,
   output logic [RAM_AW-1:0] o_addr
);

   localparam logic [RAM_AW-1:0] LAST_WORD = '1;

   logic [RAM_AW-1:0] r_cnt;
   logic              r_busy;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt  <= '0;
         r_busy <= CLEAR_ON_RESET;
      end else if (i_start) begin
         r_cnt  <= '0;
         r_busy <= 1'b1;
      end else if (r_busy) begin
         r_cnt <= r_cnt + 1'b1;
         if (r_cnt == LAST_WORD) begin
            r_busy <= 1'b0;
         end
      end
   end

   assign o_busy = r_busy;
   assign o_done = r_busy & (r_cnt == LAST_WORD);
   assign o_addr = r_cnt;

endmodule

// File: rtl/ram4k16_busctl.sv
// ram4k16_busctl
//   Bus-cycle controller between the emulated 68000 bus and a 4k x 16
//   dual-byte RAM. Decodes an 8 KB window, converts AS_n/UDS_n/LDS_n/RW
//   cycles into registered active-low RAM strobes and lane selects, captures
//   read data and drives DTACK_n. Optionally zero-fills the RAM after reset.
// Ports:
//   i_EMU_MCLK, i_EMU_MRST      clock, asynchronous active-high reset
//   i_CPU_ADDR[22:0]            CPU A23:A1 (bit 0 here is A1)
//   i_CPU_AS_n/UDS_n/LDS_n/RW   CPU strobes and direction (1 = read)
//   i_CPU_DOUT / o_CPU_DIN      CPU write data / registered read data
//   o_CPU_DTACK_n               transfer acknowledge
//   o_RAM_ADDR/DIN, i_RAM_DOUT  RAM word address, write data, read data
//   o_RAM_WR_n/RD_n             RAM strobes
//   o_RAM_SEL0_n/SEL1_n         upper (15:8) / lower (7:0) byte selects
//   o_INIT_BUSY                 high while the zero-fill runs
module ram4k16_busctl
   import ram4k16_busctl_pkg::*;
#(
   parameter logic [10:0] ADDR_MATCH     = 11'h030,
   parameter int          WAIT_CYCLES    = 1,
   parameter logic        CLEAR_ON_RESET = 1'b1
) (
   input  logic              i_EMU_MCLK,
   input  logic              i_EMU_MRST,
   input  logic [22:0]       i_CPU_ADDR,
   input  logic              i_CPU_AS_n,
   input  logic              i_CPU_UDS_n,
   input  logic              i_CPU_LDS_n,
   input  logic              i_CPU_RW,
   input  logic [RAM_DW-1:0] i_CPU_DOUT,
   output logic [RAM_DW-1:0] o_CPU_DIN,
   output logic              o_CPU_DTACK_n,
   output logic [RAM_AW-1:0] o_RAM_ADDR,
   output logic [RAM_DW-1:0] o_RAM_DIN,
   input  logic [RAM_DW-1:0] i_RAM_DOUT,
   output logic              o_RAM_WR_n,
   output logic              o_RAM_RD_n,
   output logic              o_RAM_SEL0_n,
   output logic              o_RAM_SEL1_n,
   output logic              o_INIT_BUSY
);

   // Last value of the 2-bit wait counter before leaving STROBE.
   localparam logic [1:0] WAIT_LAST = 2'(WAIT_CYCLES - 1);

   state_t            r_state, w_state_nxt;
   logic              r_rw, w_rw_nxt;
   logic              r_lane0, w_lane0_nxt;
   logic              r_lane1, w_lane1_nxt;
   logic [1:0]        r_wait, w_wait_nxt;
   logic              r_abort, w_abort_nxt;
   logic [RAM_AW-1:0] r_ram_addr, w_ram_addr_nxt;
   logic [RAM_DW-1:0] r_ram_din, w_ram_din_nxt;
   logic [RAM_DW-1:0] r_cpu_din, w_cpu_din_nxt;
   logic              r_wr_n, w_wr_n_nxt;
   logic              r_rd_n, w_rd_n_nxt;
   logic              r_sel0_n, w_sel0_n_nxt;
   logic              r_sel1_n, w_sel1_n_nxt;
   logic              r_dtack_n, w_dtack_n_nxt;

   logic              w_hit;
   logic              w_clr_busy;
   logic              w_clr_done;
   logic [RAM_AW-1:0] w_clr_addr;

   // i_CPU_ADDR[22:12] is A23:A13, i_CPU_ADDR[11:0] is the RAM word address.
   assign w_hit = ~i_CPU_AS_n & (i_CPU_ADDR[22:12] == ADDR_MATCH)
                  & ~(i_CPU_UDS_n & i_CPU_LDS_n);

   ram4k16_init_clr #(
      .CLEAR_ON_RESET (CLEAR_ON_RESET)
   ) u_init_clr (
      .i_clk   (i_EMU_MCLK),
      .i_rst   (i_EMU_MRST),
      .i_start (1'b0),
      .o_busy  (w_clr_busy),
      .o_done  (w_clr_done),
      .o_addr  (w_clr_addr)
   );

   // All RAM/CPU outputs are registered: the next-state logic computes the
   // value each output must carry during the state being entered, so strobes
   // are glitch-free and fall back to inactive asynchronously on reset.
   always_comb begin
      w_state_nxt    = r_state;
      w_rw_nxt       = r_rw;
      w_lane0_nxt    = r_lane0;
      w_lane1_nxt    = r_lane1;
      w_wait_nxt     = r_wait;
      w_abort_nxt    = r_abort;
      w_ram_addr_nxt = r_ram_addr;
      w_ram_din_nxt  = r_ram_din;
      w_cpu_din_nxt  = r_cpu_din;
      w_wr_n_nxt     = STROBE_OFF;
      w_rd_n_nxt     = STROBE_OFF;
      w_sel0_n_nxt   = STROBE_OFF;
      w_sel1_n_nxt   = STROBE_OFF;
      w_dtack_n_nxt  = r_dtack_n;

      unique case (r_state)
         ST_INIT: begin
            // The word presented after this edge is the current count, so
            // the last word is still written on the edge that leaves INIT.
            w_wr_n_nxt     = 1'b0;
            w_sel0_n_nxt   = 1'b0;
            w_sel1_n_nxt   = 1'b0;
            w_ram_addr_nxt = w_clr_addr;
            w_ram_din_nxt  = '0;
            if (w_clr_done) begin
               w_state_nxt = ST_IDLE;
            end
         end

         ST_IDLE: begin
            w_dtack_n_nxt = 1'b1;
            if (w_hit) begin
               w_ram_addr_nxt = i_CPU_ADDR[RAM_AW-1:0];
               w_ram_din_nxt  = i_CPU_DOUT;
               w_rw_nxt       = i_CPU_RW;
               w_lane0_nxt    = ~i_CPU_UDS_n;
               w_lane1_nxt    = ~i_CPU_LDS_n;
               w_state_nxt    = ST_SETUP;
            end
         end

         ST_SETUP: begin
            if (i_CPU_AS_n) begin
               w_state_nxt = ST_RELEASE;
            end else begin
               w_state_nxt  = ST_STROBE;
               w_wait_nxt   = '0;
               w_abort_nxt  = 1'b0;
               w_rd_n_nxt   = ~r_rw;
               w_wr_n_nxt   = r_rw;
               w_sel0_n_nxt = ~r_lane0;
               w_sel1_n_nxt = ~r_lane1;
            end
         end

         ST_STROBE: begin
            if (r_wait == WAIT_LAST) begin
               if (r_rw) begin
                  w_cpu_din_nxt = i_RAM_DOUT;
               end
               // A CPU that dropped AS_n mid-strobe gets no acknowledge; the
               // RAM access itself has already happened.
               if (r_abort | i_CPU_AS_n) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt   = ST_ACK;
                  w_dtack_n_nxt = 1'b0;
               end
            end else begin
               w_wait_nxt   = r_wait + 2'd1;
               w_abort_nxt  = r_abort | i_CPU_AS_n;
               w_rd_n_nxt   = ~r_rw;
               w_wr_n_nxt   = r_rw;
               w_sel0_n_nxt = ~r_lane0;
               w_sel1_n_nxt = ~r_lane1;
            end
         end

         ST_ACK: begin
            if (i_CPU_AS_n) begin
               w_dtack_n_nxt = 1'b1;
               w_state_nxt   = ST_IDLE;
            end
         end

         ST_RELEASE: begin
            w_state_nxt = ST_IDLE;
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_EMU_MCLK or posedge i_EMU_MRST) begin
      if (i_EMU_MRST) begin
         r_state    <= CLEAR_ON_RESET ? ST_INIT : ST_IDLE;
         r_rw       <= 1'b1;
         r_lane0    <= 1'b0;
         r_lane1    <= 1'b0;
         r_wait     <= '0;
         r_abort    <= 1'b0;
         r_ram_addr <= '0;
         r_ram_din  <= '0;
         r_cpu_din  <= '0;
         r_wr_n     <= STROBE_OFF;
         r_rd_n     <= STROBE_OFF;
         r_sel0_n   <= STROBE_OFF;
         r_sel1_n   <= STROBE_OFF;
         r_dtack_n  <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_rw       <= w_rw_nxt;
         r_lane0    <= w_lane0_nxt;
         r_lane1    <= w_lane1_nxt;
         r_wait     <= w_wait_nxt;
         r_abort    <= w_abort_nxt;
         r_ram_addr <= w_ram_addr_nxt;
         r_ram_din  <= w_ram_din_nxt;
         r_cpu_din  <= w_cpu_din_nxt;
         r_wr_n     <= w_wr_n_nxt;
         r_rd_n     <= w_rd_n_nxt;
         r_sel0_n   <= w_sel0_n_nxt;
         r_sel1_n   <= w_sel1_n_nxt;
         r_dtack_n  <= w_dtack_n_nxt;
      end
   end

   assign o_CPU_DIN     = r_cpu_din;
   assign o_CPU_DTACK_n = r_dtack_n;
   assign o_RAM_ADDR    = r_ram_addr;
   assign o_RAM_DIN     = r_ram_din;
   assign o_RAM_WR_n    = r_wr_n;
   assign o_RAM_RD_n    = r_rd_n;
   assign o_RAM_SEL0_n  = r_sel0_n;
   assign o_RAM_SEL1_n  = r_sel1_n;
   assign o_INIT_BUSY   = w_clr_busy;

endmodule

// File: tb/tb_ram4k16_busctl.sv
// tb_ram4k16_busctl
//   Bench for ram4k16_busctl. Instance A uses the default parameters
//   (zero-fill, one wait cycle); instance B has WAIT_CYCLES=3 and no fill.
//   Each instance drives a behavioural RAM that samples on the falling edge.
module tb_ram4k16_busctl;

   logic clk;
   logic rst;
   logic ram_poison;

   logic [22:0] a_addr, b_addr;
   logic        a_as_n, a_uds_n, a_lds_n, a_rw;
   logic        b_as_n, b_uds_n, b_lds_n, b_rw;
   logic [15:0] a_dout, b_dout, a_din, b_din;
   logic        a_dtack_n, b_dtack_n;
   logic [11:0] a_ram_addr, b_ram_addr;
   logic [15:0] a_ram_din, b_ram_din, a_ram_dout, b_ram_dout;
   logic        a_wr_n, a_rd_n, a_sel0_n, a_sel1_n, a_busy;
   logic        b_wr_n, b_rd_n, b_sel0_n, b_sel1_n, b_busy;

   logic [15:0] mem_a   [0:4095];
   logic [15:0] mem_b   [0:4095];
   logic [15:0] model_a [0:4095];
   logic [15:0] model_b [0:4095];
   logic [15:0] exp_q [$];

   int errors;
   int checks;

   ram4k16_busctl u_dut_a (
      .i_EMU_MCLK (clk),        .i_EMU_MRST (rst),
      .i_CPU_ADDR (a_addr),     .i_CPU_AS_n (a_as_n),
      .i_CPU_UDS_n (a_uds_n),   .i_CPU_LDS_n (a_lds_n),
      .i_CPU_RW (a_rw),         .i_CPU_DOUT (a_dout),
      .o_CPU_DIN (a_din),       .o_CPU_DTACK_n (a_dtack_n),
      .o_RAM_ADDR (a_ram_addr), .o_RAM_DIN (a_ram_din),
      .i_RAM_DOUT (a_ram_dout), .o_RAM_WR_n (a_wr_n),
      .o_RAM_RD_n (a_rd_n),     .o_RAM_SEL0_n (a_sel0_n),
      .o_RAM_SEL1_n (a_sel1_n), .o_INIT_BUSY (a_busy)
   );

   ram4k16_busctl #(.WAIT_CYCLES(3), .CLEAR_ON_RESET(1'b0)) u_dut_b (
      .i_EMU_MCLK (clk),        .i_EMU_MRST (rst),
      .i_CPU_ADDR (b_addr),     .i_CPU_AS_n (b_as_n),
      .i_CPU_UDS_n (b_uds_n),   .i_CPU_LDS_n (b_lds_n),
      .i_CPU_RW (b_rw),         .i_CPU_DOUT (b_dout),
      .o_CPU_DIN (b_din),       .o_CPU_DTACK_n (b_dtack_n),
      .o_RAM_ADDR (b_ram_addr), .o_RAM_DIN (b_ram_din),
      .i_RAM_DOUT (b_ram_dout), .o_RAM_WR_n (b_wr_n),
      .o_RAM_RD_n (b_rd_n),     .o_RAM_SEL0_n (b_sel0_n),
      .o_RAM_SEL1_n (b_sel1_n), .o_INIT_BUSY (b_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      if (ram_poison) begin
         for (int i = 0; i < 4096; i++) mem_a[i] <= 16'hDEAD;
      end else begin
         if (!a_wr_n && !a_sel0_n) mem_a[a_ram_addr][15:8] <= a_ram_din[15:8];
         if (!a_wr_n && !a_sel1_n) mem_a[a_ram_addr][7:0]  <= a_ram_din[7:0];
         if (!a_rd_n) a_ram_dout <= mem_a[a_ram_addr];
      end
   end

   always @(negedge clk) begin
      if (ram_poison) begin
         for (int i = 0; i < 4096; i++) mem_b[i] <= 16'hDEAD;
      end else begin
         if (!b_wr_n && !b_sel0_n) mem_b[b_ram_addr][15:8] <= b_ram_din[15:8];
         if (!b_wr_n && !b_sel1_n) mem_b[b_ram_addr][7:0]  <= b_ram_din[7:0];
         if (!b_rd_n) b_ram_dout <= mem_b[b_ram_addr];
      end
   end

   // One CPU bus cycle; called and returns at posedge+1. lat is the number of
   // edges from the hit-sampling edge to the one that drops DTACK_n (-1: none).
   task automatic access(input bit useb, input logic [23:0] baddr, input logic rw,
                         input logic uds_n, input logic lds_n, input logic [15:0] wdata,
                         input int budget, input string tag, output int strobes,
                         output bit s0_seen, output bit s1_seen, output int lat);
      logic [11:0] waddr;
      logic [10:0] win;
      bit          hit;
      logic [15:0] exp_v, got_din, rdin;
      logic [11:0] ra;
      logic        wr, rd, s0, s1, dt;
      waddr = baddr[12:1];
      win   = baddr[23:13];
      hit   = (win == 11'h030) && !(uds_n && lds_n);
      strobes = 0; s0_seen = 0; s1_seen = 0; lat = -1; got_din = '0;
      if (useb) begin
         b_addr = baddr[23:1]; b_rw = rw; b_uds_n = uds_n; b_lds_n = lds_n;
         b_dout = wdata; b_as_n = 1'b0;
      end else begin
         a_addr = baddr[23:1]; a_rw = rw; a_uds_n = uds_n; a_lds_n = lds_n;
         a_dout = wdata; a_as_n = 1'b0;
      end
      if (hit && rw) exp_q.push_back(useb ? model_b[waddr] : model_a[waddr]);
      if (hit && !rw) begin
         if (useb) begin
            if (!uds_n) model_b[waddr][15:8] = wdata[15:8];
            if (!lds_n) model_b[waddr][7:0]  = wdata[7:0];
         end else begin
            if (!uds_n) model_a[waddr][15:8] = wdata[15:8];
            if (!lds_n) model_a[waddr][7:0]  = wdata[7:0];
         end
      end
      for (int k = 1; k <= budget; k++) begin
         @(posedge clk);
         @(negedge clk);
         wr = useb ? b_wr_n : a_wr_n;       rd = useb ? b_rd_n : a_rd_n;
         s0 = useb ? b_sel0_n : a_sel0_n;   s1 = useb ? b_sel1_n : a_sel1_n;
         dt = useb ? b_dtack_n : a_dtack_n; ra = useb ? b_ram_addr : a_ram_addr;
         rdin = useb ? b_ram_din : a_ram_din;
         if (!wr || !rd) begin
            strobes++;
            if (!s0) s0_seen = 1;
            if (!s1) s1_seen = 1;
            checks++;
            if (ra !== waddr) begin
               errors++;
               $display("FAIL %s ram_addr: got %h want %h", tag, ra, waddr);
            end
            if (!wr) begin
               checks++;
               if (rdin !== wdata) begin
                  errors++;
                  $display("FAIL %s ram_din: got %h want %h", tag, rdin, wdata);
               end
            end
         end
         if (!dt) begin
            lat = k - 1;
            got_din = useb ? b_din : a_din;
            break;
         end
      end
      if (hit && rw && exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         if (lat >= 0) begin
            checks++;
            if (got_din !== exp_v) begin
               errors++;
               $display("FAIL %s read_data: got %h want %h", tag, got_din, exp_v);
            end
         end
      end
      // DTACK_n must hold while AS_n stays low, and rise on the edge that
      // first samples AS_n high.
      @(posedge clk);
      #1;
      dt = useb ? b_dtack_n : a_dtack_n;
      checks++;
      if (dt !== (lat < 0)) begin
         errors++;
         $display("FAIL %s dtack_hold: got %b want %b", tag, dt, (lat < 0));
      end
      if (useb) begin b_as_n = 1'b1; b_uds_n = 1'b1; b_lds_n = 1'b1; end
      else begin a_as_n = 1'b1; a_uds_n = 1'b1; a_lds_n = 1'b1; end
      @(posedge clk);
      @(negedge clk);
      dt = useb ? b_dtack_n : a_dtack_n;
      checks++;
      if (dt !== 1'b1) begin
         errors++;
         $display("FAIL %s dtack_release: got %b want 1", tag, dt);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      checks++;
      if ({a_dtack_n, a_wr_n, a_rd_n, a_sel0_n, a_sel1_n} !== 5'b11111) begin
         errors++;
         $display("FAIL reset_strobes_a: got %b want 11111",
                  {a_dtack_n, a_wr_n, a_rd_n, a_sel0_n, a_sel1_n});
      end
      checks++;
      if ({a_din, a_ram_addr, a_ram_din} !== 44'h0) begin
         errors++;
         $display("FAIL reset_data_a: got %h want 0", {a_din, a_ram_addr, a_ram_din});
      end
      checks++;
      if (a_busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_busy_a: got %b want 1", a_busy);
      end
      checks++;
      if (b_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy_b: got %b want 0", b_busy);
      end
      checks++;
      if ({b_dtack_n, b_wr_n, b_rd_n, b_sel0_n, b_sel1_n} !== 5'b11111) begin
         errors++;
         $display("FAIL reset_strobes_b: got %b want 11111",
                  {b_dtack_n, b_wr_n, b_rd_n, b_sel0_n, b_sel1_n});
      end
   endtask

   // Called right after reset release at posedge+1.
   task automatic test_init();
      int wr_cnt;
      wr_cnt = 0;
      for (int k = 1; k <= 4097; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (!a_wr_n) wr_cnt++;
         if (k == 1) begin
            checks++;
            if ({a_ram_addr, a_ram_din, a_sel0_n, a_sel1_n} !== 30'h0) begin
               errors++;
               $display("FAIL init_first_word: got %h want 0",
                        {a_ram_addr, a_ram_din, a_sel0_n, a_sel1_n});
            end
         end
         if (k == 4095) begin
            checks++;
            if (a_busy !== 1'b1) begin
               errors++;
               $display("FAIL init_busy_4095: got %b want 1", a_busy);
            end
         end
         if (k == 4096) begin
            checks++;
            if (a_busy !== 1'b0) begin
               errors++;
               $display("FAIL init_busy_4096: got %b want 0", a_busy);
            end
            checks++;
            if (a_ram_addr !== 12'hFFF) begin
               errors++;
               $display("FAIL init_last_addr: got %h want fff", a_ram_addr);
            end
         end
      end
      checks++;
      if (wr_cnt !== 4096) begin
         errors++;
         $display("FAIL init_write_count: got %0d want 4096", wr_cnt);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_fill_readback();
      int st, lat;
      bit s0, s1;
      logic [23:0] addrs [3];
      addrs[0] = 24'h060000; addrs[1] = 24'h060FFE; addrs[2] = 24'h061FFE;
      for (int i = 0; i < 3; i++) begin
         access(0, addrs[i], 1'b1, 1'b0, 1'b0, 16'h0000, 20, "fill_rd", st, s0, s1, lat);
         checks++;
         if (lat !== 2) begin
            errors++;
            $display("FAIL fill_rd_latency: got %0d want 2", lat);
         end
      end
   endtask

   task automatic test_word_rw();
      int st, lat;
      bit s0, s1;
      access(0, 24'h060010, 1'b0, 1'b0, 1'b0, 16'hA55A, 20, "word_wr", st, s0, s1, lat);
      checks++;
      if ({st, s0, s1, lat} !== {32'd1, 1'b1, 1'b1, 32'd2}) begin
         errors++;
         $display("FAIL word_wr_shape: got strobes=%0d sel0=%b sel1=%b lat=%0d want 1 1 1 2",
                  st, s0, s1, lat);
      end
      access(0, 24'h060010, 1'b1, 1'b0, 1'b0, 16'h0000, 20, "word_rd", st, s0, s1, lat);
      checks++;
      if ({st, lat} !== {32'd1, 32'd2}) begin
         errors++;
         $display("FAIL word_rd_shape: got strobes=%0d lat=%0d want 1 2", st, lat);
      end
   endtask

   task automatic test_uds_write();
      int st, lat;
      bit s0, s1;
      access(0, 24'h060010, 1'b0, 1'b0, 1'b1, 16'h12FF, 20, "uds_wr", st, s0, s1, lat);
      checks++;
      if ({st, s0, s1, lat} !== {32'd1, 1'b1, 1'b0, 32'd2}) begin
         errors++;
         $display("FAIL uds_wr_shape: got strobes=%0d sel0=%b sel1=%b lat=%0d want 1 1 0 2",
                  st, s0, s1, lat);
      end
      access(0, 24'h060010, 1'b1, 1'b0, 1'b0, 16'h0000, 20, "uds_rd", st, s0, s1, lat);
      checks++;
      if (lat !== 2) begin
         errors++;
         $display("FAIL uds_rd_latency: got %0d want 2", lat);
      end
   endtask

   task automatic test_outside();
      int st, lat;
      bit s0, s1;
      access(0, 24'h062000, 1'b1, 1'b0, 1'b0, 16'h0000, 8, "outside", st, s0, s1, lat);
      checks++;
      if ({st, lat} !== {32'd0, -32'sd1}) begin
         errors++;
         $display("FAIL outside_shape: got strobes=%0d lat=%0d want 0 -1", st, lat);
      end
   endtask

   task automatic test_wait3();
      int st, lat;
      bit s0, s1;
      access(1, 24'h060020, 1'b0, 1'b0, 1'b0, 16'h3C3C, 20, "w3_wr", st, s0, s1, lat);
      checks++;
      if ({st, lat} !== {32'd3, 32'd4}) begin
         errors++;
         $display("FAIL w3_wr_shape: got strobes=%0d lat=%0d want 3 4", st, lat);
      end
      access(1, 24'h060020, 1'b1, 1'b0, 1'b0, 16'h0000, 20, "w3_rd", st, s0, s1, lat);
      checks++;
      if ({st, lat} !== {32'd3, 32'd4}) begin
         errors++;
         $display("FAIL w3_rd_shape: got strobes=%0d lat=%0d want 3 4", st, lat);
      end
   endtask

   // Reset in the middle of a write strobe, then a read hit held during the
   // restarted fill: 4096 fill edges, hit sampled on edge 4097, DTACK_n on 4099.
   task automatic test_reset_mid_strobe();
      int          lat;
      logic [15:0] exp_v, got;
      logic        busy_at_ack;
      a_addr = 24'h060040 >> 1; a_rw = 1'b0; a_uds_n = 1'b0; a_lds_n = 1'b0;
      a_dout = 16'h5555; a_as_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (a_wr_n !== 1'b0) begin
         errors++;
         $display("FAIL midrst_strobe_active: got %b want 0", a_wr_n);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({a_wr_n, a_rd_n, a_sel0_n, a_sel1_n, a_dtack_n, a_busy} !== 6'b111111) begin
         errors++;
         $display("FAIL midrst_release: got %b want 111111",
                  {a_wr_n, a_rd_n, a_sel0_n, a_sel1_n, a_dtack_n, a_busy});
      end
      a_as_n = 1'b1; a_uds_n = 1'b1; a_lds_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4096; i++) model_a[i] = 16'h0000;
      exp_q.push_back(model_a[12'h008]);
      a_addr = 24'h060010 >> 1; a_rw = 1'b1; a_uds_n = 1'b0; a_lds_n = 1'b0;
      a_as_n = 1'b0;
      rst = 1'b0;
      lat = -1; got = '0; busy_at_ack = 1'b1;
      for (int k = 1; k <= 5000; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == 1) begin
            checks++;
            if ({a_wr_n, a_ram_addr, a_busy} !== {1'b0, 12'h000, 1'b1}) begin
               errors++;
               $display("FAIL midrst_fill_restart: got wr=%b addr=%h busy=%b want 0 000 1",
                        a_wr_n, a_ram_addr, a_busy);
            end
         end
         if (!a_dtack_n) begin
            lat = k; got = a_din; busy_at_ack = a_busy;
            break;
         end
      end
      checks++;
      if (lat !== 4099) begin
         errors++;
         $display("FAIL pending_hit_latency: got %0d want 4099", lat);
      end
      checks++;
      if (busy_at_ack !== 1'b0) begin
         errors++;
         $display("FAIL pending_hit_busy: got %b want 0", busy_at_ack);
      end
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
         errors++;
         $display("FAIL pending_hit_data: got %h want %h", got, exp_v);
      end
      @(posedge clk);
      #1;
      a_as_n = 1'b1; a_uds_n = 1'b1; a_lds_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (a_dtack_n !== 1'b1) begin
         errors++;
         $display("FAIL pending_hit_release: got %b want 1", a_dtack_n);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1;
      ram_poison = 1'b1;
      a_addr = '0; a_as_n = 1'b1; a_uds_n = 1'b1; a_lds_n = 1'b1; a_rw = 1'b1; a_dout = '0;
      b_addr = '0; b_as_n = 1'b1; b_uds_n = 1'b1; b_lds_n = 1'b1; b_rw = 1'b1; b_dout = '0;
      for (int i = 0; i < 4096; i++) begin
         model_a[i] = 16'h0000;
         model_b[i] = 16'hDEAD;
      end
      repeat (3) @(posedge clk);
      #1;
      ram_poison = 1'b0;
      test_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      test_init();
      test_fill_readback();
      test_word_rw();
      test_uds_write();
      test_outside();
      test_wait3();
      test_reset_mid_strobe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
